// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width, base opcodes and the immediate format code.
// No logic, so no latency.
// No flow control; consumers decode freely.
package riscv_pkg;

  localparam int XLEN = 32;

  // Base opcode field, instruction[6:0]
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Immediate format code as seen on imm_fmt / imm_fmt_q
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator: decodes the opcode, assembles the sign-extended immediate.
// Latency: immediate/imm_fmt/imm_valid are combinational; the *_q copies lag by one clk.
// No backpressure: no handshake or stall, every edge outside reset captures the decode.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset (registered copies only)
//   instruction    raw instruction word
//   immediate      sign-extended immediate (0 for opcodes without one)
//   imm_fmt        format code, riscv_pkg::imm_fmt_e encoding
//   imm_valid      high whenever imm_fmt is not FMT_NONE
//   *_q            the three outputs above, registered
//
// Only XLEN = 32 is meaningful; the bit positions below are the RV32I field layout.
module imm_gen #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] immediate,
  output logic [2:0]      imm_fmt,
  output logic            imm_valid,
  output logic [XLEN-1:0] immediate_q,
  output logic [2:0]      imm_fmt_q,
  output logic            imm_valid_q
);

  import riscv_pkg::*;

  logic [6:0] opcode;
  logic       sign;
  imm_fmt_e   fmt;
  logic [XLEN-1:0] imm;

  assign opcode = instruction[6:0];
  assign sign   = instruction[31];

  // Single decode on opcode. The other instruction bits only move into the
  // immediate value; they never influence which format is chosen.
  always_comb begin
    fmt = FMT_NONE;
    imm = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt = FMT_I;
        imm = {{(XLEN-12){sign}}, instruction[31:20]};
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = {{(XLEN-12){sign}}, instruction[31:25], instruction[11:7]};
      end
      OP_BRANCH: begin
        // Branch offsets are halfword aligned, so bit 0 is implied zero.
        fmt = FMT_B;
        imm = {{(XLEN-13){sign}}, instruction[31], instruction[7],
               instruction[30:25], instruction[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        // Upper immediate is placed as-is; bit 31 is already the top bit.
        fmt = FMT_U;
        imm = {instruction[31:12], 12'h000};
      end
      OP_JAL: begin
        fmt = FMT_J;
        imm = {{(XLEN-21){sign}}, instruction[31], instruction[19:12],
               instruction[20], instruction[30:21], 1'b0};
      end
      default: begin
        fmt = FMT_NONE;
        imm = '0;
      end
    endcase
  end

  assign immediate = imm;
  assign imm_fmt   = fmt;
  assign imm_valid = (fmt != FMT_NONE);

  // Registered copies; reset only clears these, never the combinational path.
  always_ff @(posedge clk) begin
    if (rst) begin
      immediate_q <= '0;
      imm_fmt_q   <= FMT_NONE;
      imm_valid_q <= 1'b0;
    end else begin
      immediate_q <= immediate;
      imm_fmt_q   <= imm_fmt;
      imm_valid_q <= imm_valid;
    end
  end

endmodule

// File: tb/tb_imm_gen.sv
// Bench for imm_gen: driver pushes expected responses, monitor pops and compares.
// Combinational outputs checked 1 ns after each drive, *_q outputs one edge later.
// No backpressure in the DUT; one transaction per clock.
module tb_imm_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic [31:0] immediate, immediate_q;
  logic [2:0]  imm_fmt, imm_fmt_q;
  logic        imm_valid, imm_valid_q;

  imm_gen #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .immediate   (immediate),
    .imm_fmt     (imm_fmt),
    .imm_valid   (imm_valid),
    .immediate_q (immediate_q),
    .imm_fmt_q   (imm_fmt_q),
    .imm_valid_q (imm_valid_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        vld;
    logic        r;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %08h want %08h", name, got, want);
    end
  endtask

  // Reference: immediates rebuilt as integers from the ISA field rules.
  function automatic exp_t model(input logic [31:0] ins);
    exp_t   e;
    longint u;
    longint v;
    int     op;
    int     f;
    u  = longint'(ins);
    op = int'(ins & 32'h7F);
    v  = 0;
    f  = 0;
    case (op)
      19, 3, 103: begin
        f = 1;
        v = (u >> 20) & 4095;
        if (v >= 2048) v -= 4096;
      end
      35: begin
        f = 2;
        v = (((u >> 25) & 127) << 5) | ((u >> 7) & 31);
        if (v >= 2048) v -= 4096;
      end
      99: begin
        f = 3;
        v = (((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
            (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
        if (v >= 4096) v -= 8192;
      end
      55, 23: begin
        f = 4;
        v = u & 64'hFFFF_F000;
      end
      111: begin
        f = 5;
        v = (((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
            (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      default: begin
        f = 0;
        v = 0;
      end
    endcase
    e.imm = v[31:0];
    e.fmt = 3'(f);
    e.vld = (f != 0);
    e.r   = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] imm, input int f);
    exp_t e;
    e.imm = imm;
    e.fmt = 3'(f);
    e.vld = (f != 0);
    e.r   = 1'b0;
    return e;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic r, input exp_t e);
    exp_t t;
    @(posedge clk);
    #1;
    instruction = ins;
    rst         = r;
    t   = e;
    t.r = r;
    sb.push_back(t);
  endtask

  // Monitor: 2 ns after each edge, i.e. 1 ns after the driver's update.
  exp_t mon_e;
  exp_t mon_prev;
  logic mon_have_prev = 1'b0;

  always begin
    @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("imm",       immediate,         mon_e.imm);
      chk("fmt",       32'(imm_fmt),      32'(mon_e.fmt));
      chk("valid",     32'(imm_valid),    32'(mon_e.vld));
      if (mon_have_prev) begin
        chk("imm_q",   immediate_q,       mon_prev.imm);
        chk("fmt_q",   32'(imm_fmt_q),    32'(mon_prev.fmt));
        chk("valid_q", 32'(imm_valid_q),  32'(mon_prev.vld));
      end
      mon_prev = mon_e;
      if (mon_e.r) begin
        mon_prev.imm = 32'h0;
        mon_prev.fmt = 3'd0;
        mon_prev.vld = 1'b0;
      end
      mon_have_prev = 1'b1;
    end
  end

  logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                           7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F, 7'h7F};

  initial begin
    logic [31:0] f;
    logic [31:0] ins;
    logic        r;
    logic [31:0] lui;

    // Reset held for two cycles with arbitrary instructions on the bus.
    for (int i = 0; i < 2; i++) begin
      ins = $urandom;
      drive(ins, 1'b1, model(ins));
    end

    // First edge after release captures the LUI decode.
    f   = $urandom;
    lui = (32'h12345 << 12) | (f & 32'hF80) | 32'h37;
    drive(lui, 1'b0, mk(32'h12345000, 4));

    // I format
    f = $urandom; drive((32'h123 << 20) | (f & 32'h000F_FF80) | 32'h13, 1'b0, mk(32'h0000_0123, 1));
    f = $urandom; drive((32'hFFF << 20) | (f & 32'h000F_FF80) | 32'h13, 1'b0, mk(32'hFFFF_FFFF, 1));
    f = $urandom; drive((32'h7FF << 20) | (f & 32'h000F_FF80) | 32'h03, 1'b0, mk(32'h0000_07FF, 1));
    f = $urandom; drive((32'h800 << 20) | (f & 32'h000F_FF80) | 32'h67, 1'b0, mk(32'hFFFF_F800, 1));
    // S format
    f = $urandom; drive((32'h09 << 25) | (32'h0A << 7) | (f & 32'h01FF_F000) | 32'h23, 1'b0, mk(32'h0000_012A, 2));
    f = $urandom; drive((32'h7F << 25) | (32'h1F << 7) | (f & 32'h01FF_F000) | 32'h23, 1'b0, mk(32'hFFFF_FFFF, 2));
    f = $urandom; drive((f & 32'h01FF_F000) | 32'h23, 1'b0, mk(32'h0, 2));
    // B format
    f = $urandom; drive((32'h4 << 8) | (f & 32'h01FF_F000) | 32'h63, 1'b0, mk(32'h0000_0008, 3));
    f = $urandom; drive(32'hFE00_0F80 | (f & 32'h01FF_F000) | 32'h63, 1'b0, mk(32'hFFFF_FFFE, 3));
    // U format
    f = $urandom; drive(32'hFFFF_F000 | (f & 32'hF80) | 32'h17, 1'b0, mk(32'hFFFF_F000, 4));
    // J format
    f = $urandom; drive((32'd2  << 21) | (f & 32'hF80) | 32'h6F, 1'b0, mk(32'h0000_0004, 5));
    f = $urandom; drive((32'd16 << 21) | (f & 32'hF80) | 32'h6F, 1'b0, mk(32'h0000_0020, 5));
    // Unsupported opcode
    drive(32'hFFFF_FFFF, 1'b0, mk(32'h0, 0));

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      ins = ($urandom & 32'hFFFF_FF80) | 32'(ops[$urandom_range(0, 11)]);
      r   = ($urandom_range(0, 19) == 0);
      drive(ins, r, model(ins));
    end

    // Explicit mid-stream reset: valid decode, then reset, then recovery.
    drive(lui, 1'b0, model(lui));
    f = $urandom;
    ins = (32'h800 << 20) | (f & 32'h000F_FF80) | 32'h13;
    drive(ins, 1'b1, model(ins));
    drive(lui, 1'b0, model(lui));
    drive(32'h0000_0033, 1'b0, mk(32'h0, 0));

    repeat (3) @(posedge clk);
    #3;
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen.md
IMM_GEN -- requirements
Module: imm_gen

Interface
REQ-001 Parameter XLEN, default 32, datapath and instruction width; only 32 is supported.
REQ-002 clk  input  1  single clock; samples the registered outputs only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 instruction  input  XLEN  raw RV32I instruction word.
REQ-005 immediate  output  XLEN  combinational, sign-extended immediate for the current instruction.
REQ-006 imm_fmt  output  3  combinational format code: NONE=0, I=1, S=2, B=3, U=4, J=5.
REQ-007 imm_valid  output  1  combinational; 1 when imm_fmt is not NONE.
REQ-008 immediate_q  output  XLEN  registered copy of immediate.
REQ-009 imm_fmt_q  output  3  registered copy of imm_fmt.
REQ-010 imm_valid_q  output  1  registered copy of imm_valid.

Function
REQ-011 Decode SHALL use opcode = instruction[6:0] only; all other bits affect only the immediate value.
REQ-012 I format SHALL apply to OP_IMM 0010011, OP_LOAD 0000011 and OP_JALR 1100111; immediate = sext(instr[31:20]).
REQ-013 S format SHALL apply to OP_STORE 0100011; immediate = sext({instr[31:25], instr[11:7]}).
REQ-014 B format SHALL apply to OP_BRANCH 1100011; immediate = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); bit 0 is always 0.
REQ-015 U format SHALL apply to OP_LUI 0110111 and OP_AUIPC 0010111; immediate = {instr[31:12], 12'h000}; no shift or sign logic beyond bit placement.
REQ-016 J format SHALL apply to OP_JAL 1101111; immediate = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
REQ-017 Sign extension SHALL replicate instr[31] into every bit above the format's top bit.
REQ-018 Any other opcode, including R-type 0110011, SYSTEM 1110011, FENCE 0001111 and 1111111, SHALL give immediate = 0, imm_fmt = NONE, imm_valid = 0.
REQ-019 The immediate, imm_fmt and imm_valid path SHALL be purely combinational, with zero-cycle latency and no dependence on clk or rst.
REQ-020 On each rising clk edge with rst = 0, each *_q output SHALL load its combinational counterpart, giving exactly one cycle of latency.
REQ-021 The block SHALL contain no other state, handshake or stall input.

Reset
REQ-022 While rst = 1 at a rising edge: immediate_q = 0, imm_fmt_q = NONE, imm_valid_q = 0.
REQ-023 rst SHALL NOT affect the combinational outputs.
REQ-024 The first rising edge after rst deasserts SHALL capture the current decode normally.

Structure
REQ-025 XLEN, the opcode constants (OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL) and an imm_fmt enum typedef SHALL live in the shared riscv_pkg.
REQ-026 The block SHALL be a single module with no sub-modules.
REQ-027 The design SHALL use one combinational case on opcode and one always_ff for the *_q registers.

Verification
REQ-028 I-type checks, combinational value within 1 ns of input:
  - 12'h123 with OP_IMM -> 0x00000123
  - 12'hFFF -> 0xFFFFFFFF
  - 12'h7FF with OP_LOAD -> 0x000007FF
  - 12'h800 with OP_JALR -> 0xFFFFF800
REQ-029 S-type checks:
  - instr[31:25] = 7'h09, instr[11:7] = 5'h0A -> 0x0000012A
  - 7'h7F and 5'h1F -> 0xFFFFFFFF
  - all imm bits 0 -> 0
REQ-030 B-type checks:
  - instr[11:8] = 4'b0100, other imm bits 0 -> 0x00000008
  - instr[31] = 1, instr[30:25] = all 1, instr[11:8] = 4'hF, instr[7] = 1 -> 0xFFFFFFFE
REQ-031 U-type and J-type checks:
  - LUI with instr[31:12] = 20'h12345 -> 0x12345000
  - AUIPC with 20'hFFFFF -> 0xFFFFF000
  - JAL with instr[30:21] = 2 -> 0x00000004
  - JAL with instr[30:21] = 16 -> 0x00000020
REQ-032 Unsupported-opcode check: instruction 0xFFFFFFFF (opcode 1111111) -> immediate 0, imm_valid 0, imm_fmt NONE.
REQ-033 Register check:
  - hold rst = 1 for 2 cycles -> all *_q outputs are 0
  - release rst, apply the LUI 0x12345 instruction -> one edge later immediate_q = 0x12345000, imm_fmt_q = U, imm_valid_q = 1
  - assert rst mid-stream -> *_q outputs clear at the next edge
